// File: rtl/medidor_jogada.sv
// medidor_jogada: debounced single-button note capture with half-second tempo measurement
// Ports: clock/reset (async, active-low); enable gates capture; botoes = 13 raw note buttons;
//        jogada_valida/jogada_invalida = one-cycle event pulses; nota/tempo = last valid event;
//        pressionando/nota_atual = live view of the confirmed held button.
module medidor_jogada #(
  parameter int CLOCK_FREQ      = 5000,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TEMPO_MAX       = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [12:0] botoes,
  output logic        jogada_valida,
  output logic        jogada_invalida,
  output logic [3:0]  nota,
  output logic [3:0]  tempo,
  output logic        pressionando,
  output logic [3:0]  nota_atual
);
  localparam int HALF = CLOCK_FREQ / 2;
  localparam int SW = $clog2(HALF + 1);
  typedef enum logic [2:0] {OCIOSO, CONFIRMA, SEGURANDO, SOLTANDO, EMITE, ESPERA_SOLTAR} estado_t;
  estado_t st;
  logic [12:0] s1, smp, pat;
  logic [3:0] dcnt, unit, cod, tcap, enc, unit_n, tcap_n;
  logic [SW-1:0] sub, sub_n;
  logic [4:0] rnd;
  logic one, dbok, sat, armed;
  always_comb begin
    enc = '0;
    for (int k = 0; k < 13; k++)
      if (smp[k]) enc = 4'(k + 1);
    one = (smp != '0) && ((smp & (smp - 13'd1)) == '0);
    dbok = ({1'b0, dcnt} + 5'd1) >= 5'(DEBOUNCE_CYCLES);
    sat = unit >= 4'(TEMPO_MAX);
    sub_n = sat ? sub : (sub == SW'(HALF - 1) ? '0 : sub + 1'b1);
    unit_n = sat ? unit : (sub == SW'(HALF - 1) ? unit + 4'd1 : unit);
    // round to nearest half-second unit, then clamp to 1..TEMPO_MAX
    rnd = {1'b0, unit} + {4'd0, sub >= SW'(HALF / 2)};
    tcap_n = rnd == 5'd0 ? 4'd1 : (rnd > 5'(TEMPO_MAX) ? 4'(TEMPO_MAX) : rnd[3:0]);
  end
  assign pressionando = st == SEGURANDO;
  assign nota_atual = pressionando ? cod : 4'd0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= OCIOSO;
      // all-ones sample forces a button held through reset to be released before it can start a press
      s1 <= '1;
      smp <= '1;
      pat <= '0;
      armed <= 1'b0;
      dcnt <= '0;
      sub <= '0;
      unit <= '0;
      cod <= '0;
      tcap <= '0;
      nota <= '0;
      tempo <= '0;
      jogada_valida <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      s1 <= botoes;
      smp <= s1;
      jogada_valida <= 1'b0;
      jogada_invalida <= 1'b0;
      if (smp == '0) armed <= 1'b1;
      if (!enable && st != EMITE) st <= OCIOSO;
      else case (st)
        OCIOSO: if (smp != '0 && armed) begin
          st <= CONFIRMA;
          pat <= smp;
          dcnt <= 4'd1;
          sub <= SW'(1);
          unit <= '0;
        end
        CONFIRMA: begin
          sub <= sub_n;
          unit <= unit_n;
          if (smp != pat) st <= OCIOSO;
          else if (!dbok) dcnt <= dcnt + 4'd1;
          else if (one) begin
            st <= SEGURANDO;
            cod <= enc;
          end else begin
            jogada_invalida <= 1'b1;
            st <= ESPERA_SOLTAR;
            dcnt <= '0;
          end
        end
        SEGURANDO: begin
          sub <= sub_n;
          unit <= unit_n;
          if (smp == '0) begin
            st <= SOLTANDO;
            dcnt <= 4'd1;
            tcap <= tcap_n;
          end else if (smp != pat) begin
            jogada_invalida <= 1'b1;
            st <= ESPERA_SOLTAR;
            dcnt <= '0;
          end
        end
        SOLTANDO: begin
          sub <= sub_n;
          unit <= unit_n;
          if (smp == '0) begin
            if (dbok) st <= EMITE;
            else dcnt <= dcnt + 4'd1;
          end else if (smp == pat) st <= SEGURANDO;
          else begin
            jogada_invalida <= 1'b1;
            st <= ESPERA_SOLTAR;
            dcnt <= '0;
          end
        end
        EMITE: begin
          nota <= cod;
          tempo <= tcap;
          jogada_valida <= 1'b1;
          st <= OCIOSO;
        end
        ESPERA_SOLTAR: begin
          if (smp != '0) dcnt <= '0;
          else if (dbok) st <= OCIOSO;
          else dcnt <= dcnt + 4'd1;
        end
        default: st <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_medidor_jogada.sv
// tb_medidor_jogada: directed self-checking bench for medidor_jogada
module tb_medidor_jogada;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [12:0] botoes = '0;
  logic jogada_valida, jogada_invalida, pressionando;
  logic [3:0] nota, tempo, nota_atual;
  int vectors = 0, miscompares = 0, n_val = 0, n_inv = 0, n_both = 0;
  always #5 clock = ~clock;
  medidor_jogada dut (
    .clock(clock), .reset(reset), .enable(enable), .botoes(botoes),
    .jogada_valida(jogada_valida), .jogada_invalida(jogada_invalida),
    .nota(nota), .tempo(tempo), .pressionando(pressionando), .nota_atual(nota_atual)
  );
  always @(posedge clock) begin
    #1;
    if (jogada_valida) n_val++;
    if (jogada_invalida) n_inv++;
    if (jogada_valida && jogada_invalida) n_both++;
  end
  task automatic press(input logic [12:0] b, input int n);
    botoes = b;
    repeat (n) @(negedge clock);
    botoes = '0;
  endtask
  task automatic wait_ev(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (jogada_valida) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({jogada_valida, jogada_invalida, pressionando} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000", {jogada_valida, jogada_invalida, pressionando});
    end
    vectors++;
    if ({nota, tempo, nota_atual} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values got %h want 000", {nota, tempo, nota_atual});
    end
    reset = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clock);
  endtask
  task automatic test_basic;
    int lat, v0;
    v0 = n_val;
    press(13'h0004, 7500);
    wait_ev(lat);
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 6", lat);
    end
    vectors++;
    if ({nota, tempo} !== {4'd3, 4'd3}) begin
      miscompares++;
      $display("FAIL basic_event got nota=%0d tempo=%0d want nota=3 tempo=3", nota, tempo);
    end
    @(negedge clock);
    vectors++;
    if (jogada_valida !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse_width got %b want 0", jogada_valida);
    end
    repeat (20) @(negedge clock);
    vectors++;
    if (n_val - v0 !== 1) begin
      miscompares++;
      $display("FAIL basic_count got %0d want 1", n_val - v0);
    end
  endtask
  task automatic test_rounding;
    int lens[3] = '{3749, 3750, 600};
    logic [3:0] want[3] = '{4'd1, 4'd2, 4'd1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      press(13'h0100, lens[i]);
      wait_ev(lat);
      vectors++;
      if ({lat != 0, nota, tempo} !== {1'b1, 4'd9, want[i]}) begin
        miscompares++;
        $display("FAIL rounding_%0d got lat=%0d nota=%0d tempo=%0d want nota=9 tempo=%0d",
                 lens[i], lat, nota, tempo, want[i]);
      end
      repeat (10) @(negedge clock);
    end
  endtask
  task automatic test_saturation;
    int lat, v0;
    botoes = 13'h1000;
    repeat (10) @(negedge clock);
    v0 = n_val;
    for (int i = 0; i < 44990; i++) begin
      @(negedge clock);
      if (i % 5000 == 0) begin
        vectors++;
        if ({pressionando, nota_atual} !== {1'b1, 4'd13}) begin
          miscompares++;
          $display("FAIL hold_view@%0d got press=%b nota_atual=%0d want 1/13", i, pressionando, nota_atual);
        end
      end
    end
    vectors++;
    if (n_val !== v0) begin
      miscompares++;
      $display("FAIL hold_no_pulse got %0d want 0", n_val - v0);
    end
    botoes = '0;
    wait_ev(lat);
    vectors++;
    if ({lat != 0, nota, tempo} !== {1'b1, 4'd13, 4'd15}) begin
      miscompares++;
      $display("FAIL saturation got lat=%0d nota=%0d tempo=%0d want nota=13 tempo=15", lat, nota, tempo);
    end
    repeat (10) @(negedge clock);
  endtask
  task automatic test_glitch;
    int lat, v0, i0;
    v0 = n_val;
    i0 = n_inv;
    press(13'h0001, 2);
    repeat (20) @(negedge clock);
    vectors++;
    if ({n_val - v0, n_inv - i0} !== {32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL short_pulse got val=%0d inv=%0d want 0/0", n_val - v0, n_inv - i0);
    end
    press(13'h0001, 2000);
    repeat (2) @(negedge clock);
    press(13'h0001, 2998);
    wait_ev(lat);
    vectors++;
    if ({lat != 0, nota, tempo} !== {1'b1, 4'd1, 4'd2}) begin
      miscompares++;
      $display("FAIL drop_absorbed got lat=%0d nota=%0d tempo=%0d want nota=1 tempo=2", lat, nota, tempo);
    end
    repeat (20) @(negedge clock);
    vectors++;
    if (n_val - v0 !== 1) begin
      miscompares++;
      $display("FAIL drop_single_event got %0d want 1", n_val - v0);
    end
  endtask
  task automatic test_multi;
    int lat, v0, i0;
    v0 = n_val;
    i0 = n_inv;
    botoes = 13'h0003;
    repeat (20) @(negedge clock);
    vectors++;
    if (n_inv - i0 !== 1) begin
      miscompares++;
      $display("FAIL multi_invalid got %0d want 1", n_inv - i0);
    end
    botoes = 13'h0013;
    repeat (50) @(negedge clock);
    botoes = '0;
    repeat (20) @(negedge clock);
    vectors++;
    if ({n_val - v0, n_inv - i0} !== {32'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL multi_quiet got val=%0d inv=%0d want 0/1", n_val - v0, n_inv - i0);
    end
    press(13'h0010, 100);
    wait_ev(lat);
    vectors++;
    if ({lat != 0, nota, tempo} !== {1'b1, 4'd5, 4'd1}) begin
      miscompares++;
      $display("FAIL after_multi got lat=%0d nota=%0d tempo=%0d want nota=5 tempo=1", lat, nota, tempo);
    end
    repeat (10) @(negedge clock);
  endtask
  task automatic test_abort;
    int v0;
    v0 = n_val;
    botoes = 13'h0004;
    repeat (3000) @(negedge clock);
    vectors++;
    if (pressionando !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_hold got %b want 1", pressionando);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({jogada_valida, jogada_invalida, pressionando, nota, tempo, nota_atual} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset got nota=%0d tempo=%0d press=%b want all 0", nota, tempo, pressionando);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (500) @(negedge clock);
    botoes = '0;
    repeat (30) @(negedge clock);
    vectors++;
    if (n_val !== v0) begin
      miscompares++;
      $display("FAIL reset_discard got %0d want 0", n_val - v0);
    end
    botoes = 13'h0004;
    repeat (100) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (pressionando !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_drop got %b want 0", pressionando);
    end
    repeat (20) @(negedge clock);
    botoes = '0;
    repeat (20) @(negedge clock);
    enable = 1'b1;
    repeat (20) @(negedge clock);
    vectors++;
    if (n_val !== v0) begin
      miscompares++;
      $display("FAIL enable_discard got %0d want 0", n_val - v0);
    end
    vectors++;
    if (n_both !== 0) begin
      miscompares++;
      $display("FAIL exclusive_pulses got %0d want 0", n_both);
    end
  endtask
  initial begin
    @(negedge clock);
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_glitch;
    test_multi;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
